// File: rtl/fetch_pkg.sv
// Shared encodings for the fetch stage: FSM states and next-PC select codes.
package fetch_pkg;
  localparam logic [1:0] ST_BOOT = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HALT = 2'd2;

  localparam logic [2:0] SEL_SEQ    = 3'd0;
  localparam logic [2:0] SEL_HOLD   = 3'd1;
  localparam logic [2:0] SEL_BRANCH = 3'd2;
  localparam logic [2:0] SEL_JUMP   = 3'd3;
  localparam logic [2:0] SEL_EXC    = 3'd4;
endpackage

// File: rtl/fetch_if.sv
// Instruction-memory port and IF/ID register bundle between fetch and decode.
interface fetch_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] o_imem_addr;
  logic [DATA_W-1:0] i_imem_data;
  logic [ADDR_W-1:0] o_pc;
  logic [ADDR_W-1:0] o_pc_next;
  logic [DATA_W-1:0] o_instr;
  logic              o_valid;

  modport master (
    output o_imem_addr, o_pc, o_pc_next, o_instr, o_valid,
    input  i_imem_data
  );

  modport slave (
    input  o_imem_addr, o_pc, o_pc_next, o_instr, o_valid,
    output i_imem_data
  );
endinterface

// File: rtl/next_pc_sel.sv
// Combinational next-PC priority mux: exception > jump > branch > stall > sequential.
module next_pc_sel
  import fetch_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic [ADDR_W-1:0] pc_inc,
  input  logic [ADDR_W-1:0] exc_pc,
  input  logic              exc,
  input  logic              jump,
  input  logic [ADDR_W-1:0] jump_target,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              stall,
  output logic [ADDR_W-1:0] next_pc,
  output logic              redirect
);
  logic [2:0] sel;

  always_comb begin
    sel = SEL_SEQ;
    if (exc)               sel = SEL_EXC;
    else if (jump)         sel = SEL_JUMP;
    else if (branch_taken) sel = SEL_BRANCH;
    else if (stall)        sel = SEL_HOLD;
  end

  always_comb begin
    next_pc = pc_inc;
    case (sel)
      SEL_EXC:    next_pc = exc_pc;
      SEL_JUMP:   next_pc = jump_target;
      SEL_BRANCH: next_pc = branch_target;
      SEL_HOLD:   next_pc = pc;
      default:    next_pc = pc_inc;
    endcase
  end

  assign redirect = (sel == SEL_EXC) || (sel == SEL_JUMP) || (sel == SEL_BRANCH);
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, BOOT/RUN/HALT control and IF/ID register.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                DATA_W     = 32,
  parameter int                ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0,
  parameter int                PC_STEP    = 1,
  parameter logic [31:0]       EXC_VECTOR = 32'h0000_0040,
  parameter logic [DATA_W-1:0] HALT_INSTR = DATA_W'(32'hFFFF_FFFF)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_stall,
  input  logic              i_flush,
  input  logic              i_exc,
  input  logic              i_jump,
  input  logic [ADDR_W-1:0] i_jump_target,
  input  logic              i_branch_taken,
  input  logic [ADDR_W-1:0] i_branch_target,
  input  logic              i_resume,
  fetch_if.master           bus,
  output logic              o_halted
);
  localparam logic [ADDR_W-1:0] EXC_PC = ADDR_W'(EXC_VECTOR);

  logic [1:0]        state;
  logic [ADDR_W-1:0] pc_p0;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] next_pc;
  logic              redirect;
  logic [ADDR_W-1:0] pc_p1;
  logic [ADDR_W-1:0] pc_next_p1;
  logic [DATA_W-1:0] instr_p1;
  logic              vld_p1;

  // Wraps silently modulo 2^ADDR_W.
  assign pc_inc = pc_p0 + ADDR_W'(PC_STEP);

  next_pc_sel #(.ADDR_W(ADDR_W)) u_sel (
    .pc            (pc_p0),
    .pc_inc        (pc_inc),
    .exc_pc        (EXC_PC),
    .exc           (i_exc),
    .jump          (i_jump),
    .jump_target   (i_jump_target),
    .branch_taken  (i_branch_taken),
    .branch_target (i_branch_target),
    .stall         (i_stall),
    .next_pc       (next_pc),
    .redirect      (redirect)
  );

  // Stage boundary: IF (pc_p0) -> IF/ID (_p1)
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= ST_BOOT;
      pc_p0      <= RESET_PC;
      pc_p1      <= '0;
      pc_next_p1 <= '0;
      instr_p1   <= '0;
      vld_p1     <= 1'b0;
    end else begin
      case (state)
        ST_BOOT: begin
          vld_p1 <= 1'b0;
          state  <= ST_RUN;
        end
        ST_RUN: begin
          pc_p0 <= next_pc;
          if (redirect || i_flush) begin
            vld_p1 <= 1'b0;
          end else if (!i_stall) begin
            pc_p1      <= pc_p0;
            pc_next_p1 <= pc_inc;
            instr_p1   <= bus.i_imem_data;
            vld_p1     <= 1'b1;
            if (bus.i_imem_data == HALT_INSTR) state <= ST_HALT;
          end
        end
        ST_HALT: begin
          vld_p1 <= 1'b0;
          if (i_exc) begin
            pc_p0 <= EXC_PC;
            state <= ST_RUN;
          end else if (i_resume) begin
            state <= ST_RUN;
          end
        end
        default: state <= ST_BOOT;
      endcase
    end
  end

  assign bus.o_imem_addr = pc_p0;
  assign bus.o_pc        = pc_p1;
  assign bus.o_pc_next   = pc_next_p1;
  assign bus.o_instr     = instr_p1;
  assign bus.o_valid     = vld_p1;
  assign o_halted        = (state == ST_HALT);
endmodule
